matrix_csr_sequencer: RTL and testbench
=======================================

// Module: matrix_csr_sequencer
// PURPOSE
//  Initiator for the matrix accelerator CSR channels (vec, mat, run). Takes one host command
//  (rows, cols) and writes row size on the vec channel, column size on the mat channel and
//  run=1 on the run channel. It then tracks the ready level through busy and completion,
//  clears run, and reports done or error. Sits between the MCU bus bridge and the array controller.
// PARAMETERS
//  DATA_W      16    CSR data width; sizes occupy [7:0], run bit is [0]
//  PE_NUMBER   64    max legal row count (array width)
//  STROBE_CYC  2     cycles valid is held high per write (>=1)
//  TIMEOUT     4096  max cycles waiting on any ready edge before error
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       async active-low reset
//  cmd_valid   in   1       host command strobe
//  cmd_ready   out  1       high only in IDLE
//  cmd_rows    in   8       vector length / active PEs
//  cmd_cols    in   8       matrix column count
//  busy        out  1       high in every state except IDLE
//  done        out  1       1-cycle pulse on successful completion
//  err         out  1       sticky; cleared by next accepted command
//  err_code    out  2       0 none, 1 bad size, 2 not idle, 3 timeout
//  vec_valid   out  1       vec CSR write strobe
//  vec_data    out  DATA_W  {'0, rows}
//  vec_ready   in   1       accelerator idle level, vec channel
//  mat_valid   out  1       mat CSR write strobe
//  mat_data    out  DATA_W  {'0, cols}
//  mat_ready   in   1       accelerator idle level, mat channel
//  run_valid   out  1       run CSR write strobe
//  run_data    out  DATA_W  {'0, run}
//  run_ready   in   1       accelerator idle level, run channel
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM=IDLE; timer=0. Async assert, sync deassert use.
//  Slave latches data on rising valid edge. Rules for each write:
//   - data driven in SETUP (1 cycle, valid=0).
//   - valid high for exactly STROBE_CYC cycles while data is held stable.
//   - valid low for at least 1 cycle before the next write.
//  Data outputs hold their last value while idle.
//  FSM:
//   IDLE: on cmd_valid&cmd_ready, latch rows/cols and clear err/err_code.
//    - rows==0, cols==0 or rows>PE_NUMBER -> ERR code 1.
//    - otherwise -> CHK.
//   CHK: all three ready==1 -> VEC_SETUP, else ERR code 2 (checked in one cycle).
//   VEC_SETUP -> VEC_STB -> MAT_SETUP -> MAT_STB -> RUN_SETUP(run=1) -> RUN_STB.
//   WAIT_BUSY: wait run_ready==0 (start acknowledged).
//   WAIT_DONE: wait run_ready==1 (array and memory back to WAIT).
//   CLR_SETUP(run=0) -> CLR_STB -> DONE.
//   DONE: done=1 for 1 cycle -> IDLE.
//   ERR: err=1 for 1 cycle -> IDLE. err/err_code stay sticky after leaving ERR.
//  Timer:
//   - clears on entry to WAIT_BUSY and WAIT_DONE, counts each cycle in those states.
//   - reaching TIMEOUT-1 without the awaited edge -> ERR code 3.
//   - ERR code 3 leaves run_valid=0 and does not issue the run=0 write; host must reset.
//  Awaited edge and timeout in the same cycle: edge wins.
//  cmd_valid outside IDLE is ignored (no queueing).
//  Latency on a clean path: DONE is exactly 2+3*(1+STROBE_CYC)+Tb+Td+(1+STROBE_CYC) cycles
//   after acceptance. Tb, Td = cycles spent in WAIT_BUSY / WAIT_DONE.
//  Reset mid-operation: valids drop to 0 immediately and FSM returns to IDLE. A run=1
//   already latched in the slave is not cleared; the system resets both blocks together.
// TESTING
//  T1 rows=4, cols=3, slave model drops ready 2 cycles after run strobe, raises it 10 cycles later.
//     -> vec_data=4, mat_data=3, run 1 then 0 written once each; done pulses once; err=0.
//  T2 rows=0 or rows=65 (PE_NUMBER=64) -> no valid toggles; err=1, err_code=1; cmd_ready back next cycle.
//  T3 mat_ready=0 at acceptance -> err_code=2; no CSR strobes issued.
//  T4 slave never drops ready after run, TIMEOUT=16 -> err_code=3 after 16 cycles in WAIT_BUSY;
//     run_valid=0.
//  T5 rst_n pulsed low during MAT_STB -> mat_valid=0 same cycle; outputs at reset values;
//     a new command then completes normally.
//  T6 cmd_valid held high throughout T1 -> exactly one transaction per IDLE visit; each write
//     has data stable 1 cycle before valid rises, valid high STROBE_CYC cycles.

Source files
------------

// File: rtl/matrix_csr_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_csr_sequencer
//
// Purpose:
//   Initiator for the three CSR channels of the matrix accelerator (vec, mat,
//   run). One host command (rows, cols) is turned into:
//     1. a write of the row count on the vec channel,
//     2. a write of the column count on the mat channel,
//     3. a write of run=1 on the run channel,
//   after which the run channel's ready level is tracked through "busy"
//   (ready falls) and "complete" (ready rises again). The run bit is then
//   cleared with a run=0 write and the command finishes with a done pulse.
//   Bad sizes, a non-idle accelerator and lost handshakes end in ERR with a
//   sticky error code.
//
// Handshake semantics (host side and CSR side):
//   - Host: a command is accepted on a cycle where cmd_valid && cmd_ready.
//     cmd_ready is high only in IDLE; cmd_valid in any other state is
//     ignored, nothing is queued.
//   - CSR channels: the slave latches data on the rising edge of *_valid.
//     Every write is a SETUP cycle (data driven, valid low) followed by
//     STROBE_CYC cycles of valid high with data held stable. The SETUP
//     cycle of the following write guarantees valid is low for at least one
//     cycle between writes. *_ready is a level (accelerator idle), not a
//     per-write acknowledge.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        host command handshake
//   cmd_rows, cmd_cols         command payload (8 bits each)
//   busy                       high in every state except IDLE
//   done                       one-cycle pulse on successful completion
//   err, err_code              sticky error flag / code
//                              (0 none, 1 bad size, 2 not idle, 3 timeout)
//   vec_valid/vec_data/vec_ready   vec CSR channel (row count)
//   mat_valid/mat_data/mat_ready   mat CSR channel (column count)
//   run_valid/run_data/run_ready   run CSR channel (run bit in [0])
//   fsm_state                  current FSM state, for debug/observation
// -----------------------------------------------------------------------------
module matrix_csr_sequencer #(
    parameter int DATA_W     = 16,
    parameter int PE_NUMBER  = 64,
    parameter int STROBE_CYC = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_rows,
    input  logic [7:0]        cmd_cols,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              vec_valid,
    output logic [DATA_W-1:0] vec_data,
    input  logic              vec_ready,
    output logic              mat_valid,
    output logic [DATA_W-1:0] mat_data,
    input  logic              mat_ready,
    output logic              run_valid,
    output logic [DATA_W-1:0] run_data,
    input  logic              run_ready,
    output logic [3:0]        fsm_state
);

    localparam int STB_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SIZE    = 2'd1;
    localparam logic [1:0] ERR_NIDLE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHK       = 4'd1,
        S_VEC_SETUP = 4'd2,
        S_VEC_STB   = 4'd3,
        S_MAT_SETUP = 4'd4,
        S_MAT_STB   = 4'd5,
        S_RUN_SETUP = 4'd6,
        S_RUN_STB   = 4'd7,
        S_WAIT_BUSY = 4'd8,
        S_WAIT_DONE = 4'd9,
        S_CLR_SETUP = 4'd10,
        S_CLR_STB   = 4'd11,
        S_DONE      = 4'd12,
        S_ERR       = 4'd13
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         code_nxt;     // code captured when ERR is entered

    logic [7:0]         rows_q;
    logic [7:0]         cols_q;
    logic               run_bit;
    logic [STB_W-1:0]   stb_cnt;
    logic [TMR_W-1:0]   tmr;

    logic               accept;
    logic               size_bad;
    logic               all_ready;
    logic               in_stb;
    logic               in_wait;
    logic               stb_last;
    logic               tmr_last;

    assign accept    = cmd_valid && cmd_ready;
    assign size_bad  = (cmd_rows == 8'd0) || (cmd_cols == 8'd0) ||
                       ({24'd0, cmd_rows} > 32'(PE_NUMBER));
    assign all_ready = vec_ready && mat_ready && run_ready;

    assign in_stb  = (state == S_VEC_STB) || (state == S_MAT_STB) ||
                     (state == S_RUN_STB) || (state == S_CLR_STB);
    assign in_wait = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

    assign stb_last = (stb_cnt == STB_W'(STROBE_CYC - 1));
    assign tmr_last = (tmr == TMR_W'(TIMEOUT - 1));

    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        code_nxt  = ERR_NONE;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (size_bad) begin
                        state_nxt = S_ERR;
                        code_nxt  = ERR_SIZE;
                    end else begin
                        state_nxt = S_CHK;
                    end
                end
            end
            // Single-cycle look at all three idle levels; no retry.
            S_CHK: begin
                if (all_ready) begin
                    state_nxt = S_VEC_SETUP;
                end else begin
                    state_nxt = S_ERR;
                    code_nxt  = ERR_NIDLE;
                end
            end
            S_VEC_SETUP: state_nxt = S_VEC_STB;
            S_VEC_STB:   if (stb_last) state_nxt = S_MAT_SETUP;
            S_MAT_SETUP: state_nxt = S_MAT_STB;
            S_MAT_STB:   if (stb_last) state_nxt = S_RUN_SETUP;
            S_RUN_SETUP: state_nxt = S_RUN_STB;
            S_RUN_STB:   if (stb_last) state_nxt = S_WAIT_BUSY;
            // The awaited level is tested before the timer, so an edge that
            // arrives on the last counted cycle still wins.
            S_WAIT_BUSY: begin
                if (!run_ready) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmr_last) begin
                    state_nxt = S_ERR;
                    code_nxt  = ERR_TIMEOUT;
                end
            end
            S_WAIT_DONE: begin
                if (run_ready) begin
                    state_nxt = S_CLR_SETUP;
                end else if (tmr_last) begin
                    state_nxt = S_ERR;
                    code_nxt  = ERR_TIMEOUT;
                end
            end
            S_CLR_SETUP: state_nxt = S_CLR_STB;
            S_CLR_STB:   if (stb_last) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            S_ERR:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (pure decode of the current state, so an asynchronous
    // reset drops every strobe immediately)
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        vec_valid = 1'b0;
        mat_valid = 1'b0;
        run_valid = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_VEC_STB: vec_valid = 1'b1;
            S_MAT_STB: mat_valid = 1'b1;
            S_RUN_STB: run_valid = 1'b1;
            S_CLR_STB: run_valid = 1'b1;
            S_DONE:    done      = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Strobe length counter: counts cycles spent in the current *_STB state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_cnt <= '0;
        end else if (in_stb && (state_nxt == state)) begin
            stb_cnt <= stb_cnt + 1'b1;
        end else begin
            stb_cnt <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Handshake timer: zero on entry to each wait state, +1 per cycle there.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (in_wait && (state_nxt == state)) begin
            tmr <= tmr + 1'b1;
        end else begin
            tmr <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Command latch and CSR data registers. Data is loaded on entry to the
    // matching SETUP state, so it is stable for the whole SETUP cycle and
    // the strobe that follows, and holds its value while idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q  <= 8'd0;
            cols_q  <= 8'd0;
            run_bit <= 1'b0;
        end else begin
            if (accept) begin
                rows_q <= cmd_rows;
                cols_q <= cmd_cols;
            end
            if ((state_nxt == S_RUN_SETUP) && (state != S_RUN_SETUP)) begin
                run_bit <= 1'b1;
            end else if ((state_nxt == S_CLR_SETUP) && (state != S_CLR_SETUP)) begin
                run_bit <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_data <= '0;
            mat_data <= '0;
        end else begin
            if ((state_nxt == S_VEC_SETUP) && (state != S_VEC_SETUP)) begin
                vec_data <= {{(DATA_W-8){1'b0}}, rows_q};
            end
            if ((state_nxt == S_MAT_SETUP) && (state != S_MAT_SETUP)) begin
                mat_data <= {{(DATA_W-8){1'b0}}, cols_q};
            end
        end
    end

    assign run_data = {{(DATA_W-1){1'b0}}, run_bit};

    // -------------------------------------------------------------------------
    // Sticky error flag/code. Entering ERR takes priority over the clear on
    // acceptance, because a bad-size command is accepted and rejected in the
    // same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if ((state_nxt == S_ERR) && (state != S_ERR)) begin
            err      <= 1'b1;
            err_code <= code_nxt;
        end else if (accept) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_matrix_csr_sequencer.sv
module tb_matrix_csr_sequencer;

    localparam int S   = 2;
    localparam int TO  = 16;
    localparam int PE  = 64;
    localparam int BIG = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_rows;
    logic [7:0]  cmd_cols;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        vec_valid;
    logic [15:0] vec_data;
    logic        vec_ready;
    logic        mat_valid;
    logic [15:0] mat_data;
    logic        mat_ready;
    logic        run_valid;
    logic [15:0] run_data;
    logic        run_ready;
    logic [3:0]  fsm_state;

    matrix_csr_sequencer #(
        .DATA_W(16), .PE_NUMBER(PE), .STROBE_CYC(S), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
        .mat_valid(mat_valid), .mat_data(mat_data), .mat_ready(mat_ready),
        .run_valid(run_valid), .run_data(run_data), .run_ready(run_ready),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_done   = 0;
    int last_done_cyc = -1;
    int last_err_cyc  = -1;
    logic prev_err = 1'b0;

    logic [17:0] exp_q[$];   // {channel, data}: 0 vec, 1 mat, 2 run

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, fsm %0d)",
                     name, act, exp, cyc, fsm_state);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (cycle %0d, fsm %0d)", name, cyc, fsm_state);
    endtask

    // ---------------- slave model (run channel) ----------------
    // After it latches run=1 the accelerator drops run_ready s_d1 cycles
    // later and raises it again s_d2 cycles after that (or never drops).
    int s_d1 = 2, s_d2 = 10;
    bit s_never = 1'b0;
    int s_drop = BIG, s_raise = BIG;

    function automatic bit lvl(input int c, input int d, input int r);
        return !(c >= d && c < r);
    endfunction

    initial begin
        run_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            run_ready = lvl(cyc, s_drop, s_raise);
        end
    end

    // ---------------- behavioural reference model ----------------
    // Per command: a timeline computed from the accept cycle k0. CHK is
    // k0+1; three writes of (1+S) cycles start at k0+2; the wait for
    // ready-low starts at wb = k0+2+3(1+S); each wait allows TO cycles.
    bit   m_active = 1'b0;
    int   m_k0 = 0, m_end = 0, m_accepts = 0;
    bit   m_done = 1'b0;
    logic [1:0] m_code = 2'd0;
    logic err_e = 1'b0;
    logic [1:0] code_e = 2'd0;

    task automatic model_accept(input int k0);
        int wb, rs, drop, raise, wd, tb_end, hi_c;
        bit found;
        m_active = 1'b1;
        m_k0     = k0;
        m_accepts++;
        if (cmd_rows == 8'd0 || cmd_cols == 8'd0 || int'(cmd_rows) > PE) begin
            m_end = k0 + 1; m_done = 1'b0; m_code = 2'd1;
            return;
        end
        if (!(vec_ready && mat_ready && lvl(k0 + 1, s_drop, s_raise))) begin
            m_end = k0 + 2; m_done = 1'b0; m_code = 2'd2;
            return;
        end
        exp_q.push_back({2'd0, 8'd0, cmd_rows});
        exp_q.push_back({2'd1, 8'd0, cmd_cols});
        exp_q.push_back({2'd2, 16'd1});
        rs    = k0 + 2 + 2 * (1 + S) + 1;
        drop  = s_never ? BIG : rs + s_d1;
        raise = s_never ? BIG : drop + s_d2;
        wb    = k0 + 2 + 3 * (1 + S);
        found = 1'b0; tb_end = 0;
        for (int c = wb; c < wb + TO; c++) begin
            if (!lvl(c, drop, raise)) begin tb_end = c; found = 1'b1; break; end
        end
        if (!found) begin
            m_end = wb + TO; m_done = 1'b0; m_code = 2'd3;
            return;
        end
        wd = tb_end + 1;
        found = 1'b0; hi_c = 0;
        for (int c = wd; c < wd + TO; c++) begin
            if (lvl(c, drop, raise)) begin hi_c = c; found = 1'b1; break; end
        end
        if (!found) begin
            m_end = wd + TO; m_done = 1'b0; m_code = 2'd3;
            return;
        end
        exp_q.push_back({2'd2, 16'd0});
        m_end  = hi_c + 2 + S;
        m_done = 1'b1;
        m_code = 2'd0;
    endtask

    // ---------------- compare process (every negedge) ----------------
    bit          pv[3];
    logic [15:0] pd[3];
    int          hc[3];
    int          c_now;
    bit          busy_e, done_e, v;
    logic [15:0] d;
    logic [17:0] obs, exp_w;

    always @(negedge clk) begin
        c_now = cyc;
        if (!rst_n) begin
            m_active = 1'b0;
            err_e    = 1'b0;
            code_e   = 2'd0;
            exp_q.delete();
            s_drop   = BIG;
            s_raise  = BIG;
            check("rst_busy", busy, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_valids", {vec_valid, mat_valid, run_valid}, 0);
            for (int ch = 0; ch < 3; ch++) begin
                pv[ch] = 1'b0;
                hc[ch] = 0;
            end
            pd[0] = vec_data; pd[1] = mat_data; pd[2] = run_data;
            prev_err = 1'b0;
        end else begin
            busy_e = m_active && c_now > m_k0 && c_now <= m_end;
            done_e = m_active && c_now == m_end && m_done;
            if (m_active && c_now == m_k0 + 1) begin err_e = 1'b0; code_e = 2'd0; end
            if (m_active && c_now == m_end && !m_done) begin err_e = 1'b1; code_e = m_code; end
            check("busy", busy, busy_e);
            check("cmd_ready", cmd_ready, !busy_e);
            check("done", done, done_e);
            check("err", err, err_e);
            check("err_code", err_code, code_e);
            if (done) begin n_done++; last_done_cyc = c_now; end
            if (err && !prev_err) last_err_cyc = c_now;
            prev_err = err;

            // CSR write monitor / scoreboard
            for (int ch = 0; ch < 3; ch++) begin
                v = (ch == 0) ? vec_valid : (ch == 1) ? mat_valid : run_valid;
                d = (ch == 0) ? vec_data  : (ch == 1) ? mat_data  : run_data;
                if (v && !pv[ch]) begin
                    check("setup_stable", d, pd[ch]);
                    obs = {2'(ch), d};
                    n_writes++;
                    hc[ch] = 1;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_write: got ch%0d data 0x%0h expected none (cycle %0d)",
                                 ch, d, c_now);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("csr_write", {14'd0, obs}, {14'd0, exp_w});
                    end
                    if (ch == 2 && d[0]) begin
                        s_drop  = s_never ? BIG : c_now + s_d1;
                        s_raise = s_never ? BIG : c_now + s_d1 + s_d2;
                    end
                end else if (v && pv[ch]) begin
                    check("strobe_data_stable", d, pd[ch]);
                    hc[ch]++;
                end else if (!v && pv[ch]) begin
                    check("strobe_len", hc[ch], S);
                end
                pv[ch] = v;
                pd[ch] = d;
            end

            if (m_active && c_now == m_end) m_active = 1'b0;
            if (!busy_e && !m_active && cmd_valid) model_accept(c_now);
        end
    end

    // ---------------- driver tasks (called at posedge + 2) ----------------
    task automatic issue(input logic [7:0] r, input logic [7:0] cl);
        int n0, t;
        cmd_rows  = r;
        cmd_cols  = cl;
        cmd_valid = 1'b1;
        n0 = m_accepts;
        t  = 0;
        while (m_accepts == n0 && t < 100) begin
            @(posedge clk); #2; t++;
        end
        if (m_accepts == n0) fail_bound("accept");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_active && t < 300) begin
            @(posedge clk); #2; t++;
        end
        if (m_active) fail_bound("complete");
        @(posedge clk); #2;
    endtask

    task automatic run_cmd(input logic [7:0] r, input logic [7:0] cl);
        issue(r, cl);
        wait_idle();
    endtask

    task automatic reset_pulse();
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    int w0, d0, t;
    logic [7:0] rr, cc;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rows = 8'd0; cmd_cols = 8'd0;
        vec_ready = 1'b1; mat_ready = 1'b1;
        #1;
        check("rst_vec_data", vec_data, 0);
        check("rst_mat_data", mat_data, 0);
        check("rst_run_data", run_data, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // T1: clean command
        s_d1 = 2; s_d2 = 10; s_never = 1'b0;
        w0 = n_writes;
        run_cmd(8'd4, 8'd3);
        check("t1_done_latency", last_done_cyc - m_k0, 25);
        check("t1_write_count", n_writes - w0, 4);
        check("t1_vec_data_hold", vec_data, 16'd4);
        check("t1_mat_data_hold", mat_data, 16'd3);
        check("t1_run_cleared", run_data, 16'd0);
        check("t1_err", err, 0);

        // T2: bad sizes
        w0 = n_writes;
        run_cmd(8'd0, 8'd5);
        check("t2_err", err, 1);
        check("t2_code_rows0", err_code, 1);
        check("t2_err_latency", last_err_cyc - m_k0, 1);
        run_cmd(8'd65, 8'd5);
        check("t2_code_rows65", err_code, 1);
        run_cmd(8'd64, 8'd0);
        check("t2_code_cols0", err_code, 1);
        check("t2_no_writes", n_writes - w0, 0);

        // T3: accelerator not idle
        mat_ready = 1'b0;
        w0 = n_writes;
        run_cmd(8'd4, 8'd3);
        check("t3_code", err_code, 2);
        check("t3_no_writes", n_writes - w0, 0);
        mat_ready = 1'b1;

        // T4: slave never acknowledges the run write
        s_never = 1'b1;
        run_cmd(8'd64, 8'd200);
        check("t4_code", err_code, 3);
        check("t4_err_latency", last_err_cyc - m_k0, 27);
        check("t4_run_valid", run_valid, 0);
        s_never = 1'b0;
        reset_pulse();

        // T5: reset while the mat strobe is high
        issue(8'd8, 8'd5);
        t = 0;
        while (!mat_valid && t < 50) begin @(posedge clk); #2; t++; end
        if (!mat_valid) fail_bound("mat_strobe");
        #1 rst_n = 1'b0;
        #1;
        check("t5_mat_valid", mat_valid, 0);
        check("t5_vec_valid", vec_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        check("t5_vec_data", vec_data, 0);
        check("t5_mat_data", mat_data, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        d0 = n_done;
        run_cmd(8'd12, 8'd7);
        check("t5_recovers", n_done - d0, 1);

        // T6: cmd_valid held high across several transactions
        d0 = n_done; w0 = n_writes;
        cmd_rows = 8'd4; cmd_cols = 8'd3; cmd_valid = 1'b1;
        t = m_accepts;
        while (m_accepts < t + 3 && cyc < 100000) begin
            @(posedge clk); #2;
            if (m_accepts == t && busy == 1'b0 && last_done_cyc < 0) break;
        end
        cmd_valid = 1'b0;
        wait_idle();
        check("t6_done_count", n_done - d0, 3);
        check("t6_write_count", n_writes - w0, 12);

        // Randomised commands
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 9))
                0:       rr = 8'd0;
                1:       rr = 8'($urandom_range(65, 255));
                default: rr = 8'($urandom_range(1, 64));
            endcase
            cc = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            vec_ready = ($urandom_range(0, 7) != 0);
            mat_ready = ($urandom_range(0, 7) != 0);
            s_d1 = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 4);
            s_d2 = $urandom_range(1, 12);
            run_cmd(rr, cc);
            vec_ready = 1'b1;
            mat_ready = 1'b1;
            if (err_code == 2'd3) reset_pulse();
        end

        repeat (3) @(posedge clk);
        #2;
        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
